uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 16x oversampling and 3-sample majority vote
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
  localparam logic [1:0] FLUSH_MAX = 2'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_flush_cnt;
  logic                   r_rx_prev;
  logic [1:0]             r_state;
  logic [3:0]             r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shreg;
  logic                   r_s7;
  logic                   r_s8;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_frame_err;

  logic w_rx_s;
  logic w_flushed;
  logic w_fall;
  logic w_decide;
  logic w_wrap;
  logic w_maj;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_flushed = (r_flush_cnt == FLUSH_MAX);
  assign w_fall    = r_rx_prev & ~w_rx_s;
  assign w_decide  = baud_tick & (r_tick_cnt == 4'd9);
  assign w_wrap    = baud_tick & (r_tick_cnt == 4'd15);
  assign w_maj     = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  // Edge history stays 0 until the synchronizer holds real samples, so a line
  // already low at reset release is never mistaken for a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= 2'd0;
      r_rx_prev   <= 1'b0;
    end else begin
      if (!w_flushed) begin
        r_flush_cnt <= r_flush_cnt + 2'd1;
      end
      r_rx_prev <= w_flushed ? w_rx_s : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'h00;
      r_s7        <= 1'b1;
      r_s8        <= 1'b1;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_state != S_IDLE && baud_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
        if (r_tick_cnt == 4'd7) r_s7 <= w_rx_s;
        if (r_tick_cnt == 4'd8) r_s8 <= w_rx_s;
      end
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
          end
        end
        S_START: begin
          if (w_decide && w_maj) begin
            r_state <= S_IDLE;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_decide) begin
            r_shreg <= {w_maj, r_shreg[7:1]};
          end
          if (w_wrap) begin
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        S_STOP: begin
          // Leave half a bit early so a start edge right after the stop bit is caught.
          if (w_decide) begin
            r_state <= S_IDLE;
            if (w_maj) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule
